// File: rtl/act_meter_pkg.sv
// Shared types and defaults for the sub-circuit activity meter.
// The optional Gray-coded stimulus is selected with SUBCKT_ACT_METER_GRAY_EN
// inside act_meter_vecgen; this package is identical in both builds.
package act_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_N_IN    = 4;
  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_CNT_W   = 8;

  // The sample index must be able to hold WIN_LEN itself.
  localparam int DEF_IDX_W = $clog2(DEF_WIN_LEN + 1);

  function automatic int idx_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction

endpackage

// File: rtl/act_meter_vecgen.sv
// Stimulus generator: holds the binary sequence value and maps it onto the
// sub-circuit inputs. Build option SUBCKT_ACT_METER_GRAY_EN selects
// Gray-coded vectors; without it the binary value is driven directly.
// vec_o is a pure function of the bin register, so it holds its last value
// whenever neither load nor inc is asserted.
module act_meter_vecgen
  import act_meter_pkg::*;
#(
  parameter int N_IN = DEF_N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [N_IN-1:0] seed,
  output logic [N_IN-1:0] vec_o
);

  logic [N_IN-1:0] bin;

  // Load the seed on an accepted start, otherwise step with silent wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
    end else if (load) begin
      bin <= seed;
    end else if (inc) begin
      bin <= bin + 1'b1;
    end
  end

`ifdef SUBCKT_ACT_METER_GRAY_EN
  assign vec_o = bin ^ (bin >> 1);
`else
  assign vec_o = bin;
`endif

endmodule

// File: rtl/subckt_activity_meter.sv
// Activity meter top: runs one window of WIN_LEN stimulus vectors through an
// external combinational sub-circuit, counts output toggles and output-high
// samples with saturation, and reports both over a valid/ready handshake.
// Build option SUBCKT_ACT_METER_GRAY_EN (see act_meter_vecgen) selects
// Gray-coded stimulus; counting and handshake are the same in both builds.
module subckt_activity_meter
  import act_meter_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_IN-1:0]  seed,
  output logic [N_IN-1:0]  vec_o,
  input  logic             dut_out_i,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam int               IDX_W    = idx_width(WIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             prev;
  logic             load;
  logic             inc;
  logic             last;

  assign last      = (idx == LAST_IDX);
  assign busy      = (state != IDLE);
  assign res_valid = (state == REPORT);

  act_meter_vecgen #(
    .N_IN (N_IN)
  ) u_vecgen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .inc   (inc),
    .seed  (seed),
    .vec_o (vec_o)
  );

  // Next-state and control decode; the sequence stops stepping on the last
  // sample so vec_o keeps the final vector after the window.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    inc       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        inc = !last;
        if (last) begin
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sample index and saturating counters; sample 0 only primes prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      prev       <= 1'b0;
      toggle_cnt <= '0;
      ones_cnt   <= '0;
    end else if (load) begin
      idx        <= '0;
      prev       <= 1'b0;
      toggle_cnt <= '0;
      ones_cnt   <= '0;
    end else if (state == RUN) begin
      idx  <= idx + 1'b1;
      prev <= dut_out_i;
      if ((idx != '0) && (dut_out_i != prev) && (toggle_cnt != CNT_MAX)) begin
        toggle_cnt <= toggle_cnt + 1'b1;
      end
      if (dut_out_i && (ones_cnt != CNT_MAX)) begin
        ones_cnt <= ones_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_subckt_activity_meter.sv
// Self-checking bench for subckt_activity_meter. Follows the DUT build: when
// SUBCKT_ACT_METER_GRAY_EN is defined the expected vectors and counts are the
// Gray-coded ones. A second instance with CNT_W=3 covers counter saturation.
module tb_subckt_activity_meter;

  localparam int N_IN    = 4;
  localparam int WIN_LEN = 16;
  localparam int CNT_W   = 8;

  typedef struct {
    logic [N_IN-1:0] seed;
    int              mode;
    int              hold;
    int              exp_tog;
    int              exp_ones;
  } vec_t;

  typedef struct {
    int tog;
    int ones;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N_IN-1:0]  seed = '0;
  logic [N_IN-1:0]  vec_o;
  logic             dut_out;
  logic             busy;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [CNT_W-1:0] toggle_cnt;
  logic [CNT_W-1:0] ones_cnt;
  int               mode = 0;

  logic             start_s = 1'b0;
  logic [N_IN-1:0]  vec_s;
  logic             dut_out_s;
  logic             busy_s;
  logic             valid_s;
  logic [2:0]       tog_s;
  logic [2:0]       ones_s;

  exp_t sb[$];
  exp_t last_exp;
  vec_t tbl[4];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Sub-circuit stand-in: a few different combinational functions of vec_o.
  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0:       dut_out = vec_o[0];
      1:       dut_out = 1'b1;
      2:       dut_out = ^vec_o;
      default: dut_out = vec_o[1] & vec_o[2];
    endcase
  end

  assign dut_out_s = vec_s[0];

  subckt_activity_meter #(
    .N_IN    (N_IN),
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .vec_o      (vec_o),
    .dut_out_i  (dut_out),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .toggle_cnt (toggle_cnt),
    .ones_cnt   (ones_cnt)
  );

  subckt_activity_meter #(
    .N_IN    (N_IN),
    .WIN_LEN (WIN_LEN),
    .CNT_W   (3)
  ) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_s),
    .seed       (4'd0),
    .vec_o      (vec_s),
    .dut_out_i  (dut_out_s),
    .busy       (busy_s),
    .res_valid  (valid_s),
    .res_ready  (1'b1),
    .toggle_cnt (tog_s),
    .ones_cnt   (ones_s)
  );

  function automatic logic [N_IN-1:0] fmap(input logic [N_IN-1:0] b);
`ifdef SUBCKT_ACT_METER_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard when the DUT presents an accepted result.
  task automatic check_output();
    exp_t e;
    int   budget = 0;
    while (!(res_valid && res_ready) && budget < 8) begin
      tick();
      budget++;
    end
    if (!(res_valid && res_ready)) begin
      check_val("handshake_timeout", 0, 1);
    end else if (sb.size() == 0) begin
      check_val("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      check_val("toggle_cnt", int'(toggle_cnt), e.tog);
      check_val("ones_cnt", int'(ones_cnt), e.ones);
    end
  endtask

  // Run one window, checking the vector sequence and result timing.
  task automatic apply_stimulus(input vec_t v);
    exp_t            e;
    logic [N_IN-1:0] b;
    logic [N_IN-1:0] prev_vec;
    int              t0;
    int              o0;
    res_ready = (v.hold == 0);
    seed      = v.seed;
    mode      = v.mode;
    start     = 1'b1;
    e.tog     = v.exp_tog;
    e.ones    = v.exp_ones;
    sb.push_back(e);
    tick();
    start    = 1'b0;
    seed     = ~v.seed;
    b        = v.seed;
    prev_vec = '0;
    for (int i = 0; i < WIN_LEN; i++) begin
      check_val("vec_o", int'(vec_o), int'(fmap(b)));
      if (i == 0) check_val("busy_run", int'(busy), 1);
      if (i == WIN_LEN - 1) check_val("res_valid_early", int'(res_valid), 0);
`ifdef SUBCKT_ACT_METER_GRAY_EN
      if (i > 0) check_val("gray_step", $countones(vec_o ^ prev_vec), 1);
`endif
      prev_vec = vec_o;
      b = b + 1'b1;
      tick();
    end
    check_val("res_valid_rise", int'(res_valid), 1);
    if (v.hold > 0) begin
      t0 = int'(toggle_cnt);
      o0 = int'(ones_cnt);
      for (int h = 0; h < v.hold; h++) begin
        start = (h % 2 == 0);
        check_val("valid_hold", int'(res_valid), 1);
        check_val("tog_hold", int'(toggle_cnt), t0);
        check_val("ones_hold", int'(ones_cnt), o0);
        tick();
      end
      start     = 1'b0;
      res_ready = 1'b1;
    end
    check_output();
    tick();
    check_val("busy_after", int'(busy), 0);
    check_val("valid_after", int'(res_valid), 0);
    check_val("tog_kept", int'(toggle_cnt), last_exp.tog);
    check_val("ones_kept", int'(ones_cnt), last_exp.ones);
  endtask

  initial begin
`ifdef SUBCKT_ACT_METER_GRAY_EN
    tbl[0] = '{4'd0, 0, 0, 8, 8};
    tbl[1] = '{4'd5, 1, 0, 0, 16};
    tbl[2] = '{4'd0, 2, 0, 15, 8};
    tbl[3] = '{4'd3, 3, 5, 4, 4};
`else
    tbl[0] = '{4'd0, 0, 0, 15, 8};
    tbl[1] = '{4'd5, 1, 0, 0, 16};
    tbl[2] = '{4'd0, 2, 0, 10, 8};
    tbl[3] = '{4'd3, 3, 5, 4, 4};
`endif

    #1;
    check_val("rst_vec_o", int'(vec_o), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(res_valid), 0);
    check_val("rst_tog", int'(toggle_cnt), 0);
    check_val("rst_ones", int'(ones_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) begin
      $display("[TB] window %0d seed=%0d mode=%0d", k, tbl[k].seed, tbl[k].mode);
      apply_stimulus(tbl[k]);
    end

    // Reset in the middle of a window, then a clean window.
    mode  = 0;
    seed  = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_vec_o", int'(vec_o), 0);
    check_val("mid_rst_busy", int'(busy), 0);
    check_val("mid_rst_valid", int'(res_valid), 0);
    check_val("mid_rst_tog", int'(toggle_cnt), 0);
    check_val("mid_rst_ones", int'(ones_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    apply_stimulus(tbl[0]);

    // Saturation with a 3-bit counter instance.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    begin
      int budget = 0;
      while (!valid_s && budget < 40) begin
        tick();
        budget++;
      end
    end
    check_val("sat_valid", int'(valid_s), 1);
    check_val("sat_tog", int'(tog_s), 7);
    check_val("sat_ones", int'(ones_s), 7);

    check_val("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
